// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: architectural width, canonical NOP,
// fetch FSM states and the fetch buffer entry layout.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {pc, inst} fetch entries; flush beats push and pop.
// A push into a full buffer is accepted only when a pop frees the head slot in the same cycle.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  fetch_entry_t       i_push_entry,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_full,
  output logic               o_empty,
  output fetch_entry_t       o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count = r_count;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == {CNT_W{1'b0}});
  assign o_head  = r_mem[r_rd_ptr];

  // Qualify push/pop against occupancy
  always_comb begin
    w_do_pop  = i_pop && !o_empty;
    w_do_push = i_push && (!o_full || w_do_pop);
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch initiator: owns the fetch PC, reads the single-cycle ROM,
// buffers returned words and hands them to decode over valid/ready.
module inst_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 256,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rom_read_enable,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        fetch_fault
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [XLEN-1:0] MEM_WORDS_W = XLEN'(MEM_WORDS);

  fetch_state_e     r_state;
  logic [XLEN-1:0]  r_fetch_pc;
  logic             r_fault;

  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_entry;
  logic             w_pop;
  logic             w_issue;
  logic             w_in_range;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fetch_buffer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_issue),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (redirect_valid),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_head       (w_head)
  );

  // Issue decision, range check and the entry captured on issue
  always_comb begin
    w_in_range = ({2'b00, r_fetch_pc[XLEN-1:2]} < MEM_WORDS_W);
    w_pop      = !w_empty && if_ready && !redirect_valid;
    case (r_state)
      RUN:     w_issue = !redirect_valid && (!w_full || (!w_empty && if_ready));
      FAULT:   w_issue = 1'b0;
      default: w_issue = 1'b0;
    endcase
    w_push_entry.pc = r_fetch_pc;
    if (w_in_range) begin
      w_push_entry.inst = rom_inst;
    end else begin
      w_push_entry.inst = NOP_INST;
    end
  end

  assign rom_read_enable = w_issue && w_in_range;
  assign rom_addr        = r_fetch_pc;
  assign fetch_fault     = r_fault;
  assign if_valid        = !w_empty;
  assign if_inst         = w_empty ? NOP_INST : w_head.inst;
  assign if_pc           = w_empty ? RESET_PC : w_head.pc;

  // Fetch FSM: redirect outranks sequential advance; only an aligned redirect leaves FAULT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_fetch_pc <= RESET_PC;
      r_fault    <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      if (is_word_aligned(redirect_pc)) begin
        r_state <= RUN;
        r_fault <= 1'b0;
      end else begin
        r_state <= FAULT;
        r_fault <= 1'b1;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
          end
        end
        FAULT: r_fetch_pc <= r_fetch_pc;
        default: begin
          r_state <= RUN;
          r_fault <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table, async reset
// sequences and randomized traffic against a queue-based reference model.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        rom_read_enable;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        fetch_fault;

  logic [31:0] rom [256];
  int n_chk = 0;
  int n_err = 0;

  inst_fetch #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (256),
    .BUF_DEPTH (2)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rom_read_enable (rom_read_enable),
    .rom_addr        (rom_addr),
    .rom_inst        (rom_inst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_inst         (if_inst),
    .if_pc           (if_pc),
    .fetch_fault     (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Out-of-range reads return junk so NOP substitution is observable
  assign rom_inst = (rom_addr[31:10] == 22'd0) ? rom[rom_addr[9:2]] : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return (pc < 32'h400) ? rom[pc[9:2]] : NOP;
  endfunction

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_ren;
    logic [31:0] e_addr;
    logic        e_fault;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic rv, input logic [31:0] rpc, input logic rdy,
                              input logic ev, input logic [31:0] epc, input logic eren,
                              input logic [31:0] eaddr, input logic ef);
    vec_t v;
    v = '{rv, rpc, rdy, ev, epc, eren, eaddr, ef};
    tbl.push_back(v);
  endfunction

  // Reference model: pending fetches as a queue, fetch PC and fault flag
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_fault;

  task automatic model_reset();
    mq.delete();
    m_pc    = 32'h0;
    m_fault = 1'b0;
  endtask

  task automatic mstep(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic        e_valid;
    logic        e_issue;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    ent_t        e;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    #1;
    e_valid = (mq.size() != 0);
    e_inst  = e_valid ? mq[0].inst : NOP;
    e_pc    = e_valid ? mq[0].pc : 32'h0;
    e_issue = !m_fault && !rv && (mq.size() < 2 || (e_valid && rdy));
    chk("m_valid", {31'd0, if_valid}, {31'd0, e_valid});
    chk("m_inst", if_inst, e_inst);
    chk("m_pc", if_pc, e_pc);
    chk("m_ren", {31'd0, rom_read_enable}, {31'd0, e_issue && (m_pc < 32'h400)});
    chk("m_addr", rom_addr, m_pc);
    chk("m_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    if (rv) begin
      mq.delete();
      m_pc    = rpc;
      m_fault = (rpc[1:0] != 2'b00);
    end else begin
      if (e_valid && rdy) void'(mq.pop_front());
      if (e_issue) begin
        e = '{m_pc, word_at(m_pc)};
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    int          sel;

    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    if_ready = 1'b0;

    // rv rpc rdy | valid pc ren addr fault
    add(0, 0, 0,  0, 32'h0,   1, 32'h0,   0);
    add(0, 0, 0,  1, 32'h0,   1, 32'h4,   0);
    add(0, 0, 0,  1, 32'h0,   0, 32'h8,   0);
    add(0, 0, 0,  1, 32'h0,   0, 32'h8,   0);
    add(0, 0, 0,  1, 32'h0,   0, 32'h8,   0);
    add(0, 0, 1,  1, 32'h0,   1, 32'h8,   0);
    add(0, 0, 1,  1, 32'h4,   1, 32'hC,   0);
    add(0, 0, 1,  1, 32'h8,   1, 32'h10,  0);
    add(0, 0, 1,  1, 32'hC,   1, 32'h14,  0);
    add(0, 0, 0,  1, 32'h10,  0, 32'h18,  0);
    add(1, 32'h40, 1, 1, 32'h10, 0, 32'h18, 0);
    add(0, 0, 1,  0, 32'h0,   1, 32'h40,  0);
    add(0, 0, 1,  1, 32'h40,  1, 32'h44,  0);
    add(1, 32'h3F8, 1, 1, 32'h44, 0, 32'h48, 0);
    add(0, 0, 1,  0, 32'h0,   1, 32'h3F8, 0);
    add(0, 0, 1,  1, 32'h3F8, 1, 32'h3FC, 0);
    add(0, 0, 1,  1, 32'h3FC, 0, 32'h400, 0);
    add(0, 0, 1,  1, 32'h400, 0, 32'h404, 0);
    add(0, 0, 0,  1, 32'h404, 0, 32'h408, 0);
    add(1, 32'h22, 0, 1, 32'h404, 0, 32'h40C, 0);
    add(0, 0, 1,  0, 32'h0,   0, 32'h22,  1);
    add(0, 0, 1,  0, 32'h0,   0, 32'h22,  1);
    add(1, 32'h80, 1, 0, 32'h0, 0, 32'h22, 1);
    add(0, 0, 1,  0, 32'h0,   1, 32'h80,  0);
    add(0, 0, 1,  1, 32'h80,  1, 32'h84,  0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_inst", if_inst, NOP);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_addr", rom_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      if_ready       = tbl[i].rdy;
      #1;
      chk($sformatf("t%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("t%0d_pc", i), if_pc, tbl[i].e_pc);
      chk($sformatf("t%0d_inst", i), if_inst, tbl[i].e_valid ? word_at(tbl[i].e_pc) : NOP);
      chk($sformatf("t%0d_ren", i), {31'd0, rom_read_enable}, {31'd0, tbl[i].e_ren});
      chk($sformatf("t%0d_addr", i), rom_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_fault", i), {31'd0, fetch_fault}, {31'd0, tbl[i].e_fault});
      @(negedge clk);
    end

    // Async reset while faulted, asserted mid high phase
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0022;
    if_ready       = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("pre_rst_fault", {31'd0, fetch_fault}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_fault", {31'd0, fetch_fault}, 32'd0);
    chk("async_addr0", rom_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) mstep(1'b0, 32'h0, 1'b0);

    // Async reset with a full buffer, between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, if_valid}, 32'd0);
    chk("async_pc", if_pc, 32'h0);
    chk("async_inst", if_inst, NOP);
    chk("async_addr1", rom_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) mstep(1'b0, 32'h0, 1'b1);

    // Wrap past the top of the address space
    mstep(1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (5) mstep(1'b0, 32'h0, 1'b1);

    for (int c = 0; c < 500; c++) begin
      rv  = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < 70);
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        rpc = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(1, 3));
      end else if (sel == 1) begin
        rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      end else begin
        rpc = 32'($urandom_range(0, 300) * 4);
      end
      mstep(rv, rpc, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch initiator for the single-cycle-read instruction ROM. Owns the fetch PC, drives the ROM read enable and byte address, captures returned words into a small fetch buffer, and presents them to decode over a valid/ready handshake. Accepts PC redirects from execute (branches, jumps) with flush, and substitutes NOPs for addresses past the end of instruction memory.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
- MEM_WORDS, 256, instruction memory depth in 32-bit words.
- BUF_DEPTH, 2, fetch buffer entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rom_read_enable  out  1  read strobe to instruction ROM.
- rom_addr  out  32  byte address to ROM; ROM indexes by rom_addr>>2.
- rom_inst  in  32  ROM data, combinationally valid in the same cycle as rom_addr.
- redirect_valid  in  1  one-cycle request to change the fetch PC.
- redirect_pc  in  32  new fetch PC, sampled when redirect_valid=1.
- if_valid  out  1  buffer head holds a valid instruction.
- if_ready  in  1  decode accepts the head this cycle.
- if_inst  out  32  head instruction; 32'h0000_0013 when if_valid=0.
- if_pc  out  32  PC of head instruction; RESET_PC when if_valid=0.
- fetch_fault  out  1  misaligned redirect target; level, held until cleared.

## Operation
- States: RUN, FAULT. Reset state RUN.
- Reset (async, rst_n=0): fetch_pc=RESET_PC, buffer empty, if_valid=0, fetch_fault=0, rom_addr=RESET_PC.
- rom_addr = fetch_pc, always (also in FAULT).
- In RUN, issue = !redirect_valid && (count < BUF_DEPTH || (if_valid && if_ready)).
- rom_read_enable = issue && (fetch_pc>>2) < MEM_WORDS.
- On an issue edge: push {fetch_pc, word}, where word = rom_inst if in range, else 32'h0000_0013 (NOP). fetch_pc <= fetch_pc + 4, modulo 2^32 (wrap from 32'hFFFF_FFFC to 0, with no fault).
- Pop on an edge when if_valid && if_ready. Push and pop in the same cycle with a full buffer are both legal, and count is unchanged.
- Redirect has priority over push and pop. At an edge with redirect_valid=1:
  - the buffer is flushed to count 0;
  - the head is not consumed, even if if_ready=1;
  - no push occurs;
  - fetch_pc <= redirect_pc.
- Redirect target handling:
  - If redirect_pc[1:0] != 0: go to FAULT and set fetch_fault=1.
  - Otherwise: go to or stay in RUN and set fetch_fault=0.
- In FAULT:
  - issue=0 and rom_read_enable=0;
  - the buffer drains normally through pops;
  - the only exit is an aligned redirect.
- Buffer ordering is strict FIFO. There is no bypass: ROM data always passes through the buffer.

## Timing
- Latency: address issued in cycle N gives if_valid=1 with that word in cycle N+1.
- First if_valid: the cycle after the first rising edge following rst_n deassertion.
- Throughput: one instruction per cycle while if_ready=1 and there is no redirect.
- Redirect in cycle N:
  - if_valid=0 in cycle N+1;
  - redirect_pc is issued to the ROM in cycle N+1;
  - the target word appears at the head in cycle N+2.
- Back-pressure: with if_ready=0 the buffer fills within BUF_DEPTH cycles. After that rom_read_enable=0 and fetch_pc holds.
- Reset mid-operation clears all state immediately, regardless of clk. Outputs take their reset values while rst_n=0.
- if_inst and if_pc are registered buffer outputs and do not depend combinationally on rom_inst. if_valid depends only on count.

## Structure
- Shared package riscv_pkg holds:
  - NOP_INST = 32'h0000_0013;
  - the fetch state enum {RUN, FAULT};
  - the XLEN = 32 constant.
- Sub-module fetch_buffer: a synchronous FIFO of {pc, inst} entries with push, pop, flush, count, full and empty. Flush has priority.
- The top level holds fetch_pc, the state register, the issue logic and the range check.

## Test plan
- Reset and stream: RESET_PC=0, ROM words 0..3 = A,B,C,D, if_ready=1. The decode side sees A@0, B@4, C@8, D@12 on consecutive cycles starting the cycle after reset release.
- Back-pressure: hold if_ready=0 for 5 cycles. count saturates at 2, rom_read_enable=0 from the third cycle, and fetch_pc=8. On release, A and B are delivered, then C@8 with no gap and no duplicates.
- Redirect with full buffer and if_ready=1: redirect_pc=0x40 flushes the buffer and no pop is counted. if_valid=0 for one cycle, then the word at 0x40 is delivered with if_pc=0x40.
- End of memory: redirect to 0x3F8. Words 254 and 255 come from the ROM. Addresses 0x400 and above give if_inst=32'h0000_0013 with rom_read_enable=0.
- Misaligned redirect: redirect_pc=0x22 gives fetch_fault=1 and rom_read_enable=0 with the buffer draining. A later redirect to 0x80 clears fetch_fault, and 0x80 is fetched.
- Async reset mid-stream: drop rst_n between clock edges. if_valid=0, fetch_fault=0 and rom_addr=RESET_PC take effect immediately, and streaming resumes from RESET_PC.
